pla_sweep_checker: RTL and testbench

- Exhaustive stimulus driver and response checker for one-output PLA benchmark netlists, original and D-reduced/optimized.
- Sits directly upstream of the combinational DUT pair: drives the shared input vector x and consumes y from both netlists each cycle.
- Reports the mismatch count, the first failing vector, the on-set size and, optionally, a MISR signature of the optimized output.

---
 rtl/pla_bench_pkg.sv | 16 +
 rtl/pla_misr.sv | 28 ++
 rtl/pla_sweep_checker.sv | 98 +++++++++
 tb/tb_pla_sweep_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pla_bench_pkg.sv
// Shared types and default constants for the PLA exhaustive sweep checker.
// The optional signature logic is enabled by defining SWEEP_SIG_EN.
package pla_bench_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_e;

  localparam int N_IN_DEFAULT   = 16;
  localparam int CNT_W_DEFAULT  = N_IN_DEFAULT + 1;
  localparam int MISR_W_DEFAULT = 16;
  localparam logic [MISR_W_DEFAULT-1:0] MISR_POLY_DEFAULT = 16'h8016;

endpackage

// File: rtl/pla_misr.sv
// Galois MISR compacting one serial bit per enabled cycle into a WIDTH-bit signature.
module pla_misr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h8016
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_next;

  always_comb begin
    sig_next = (sig << 1) ^ (sig[WIDTH-1] ? POLY : '0) ^ {{(WIDTH-1){1'b0}}, din};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/pla_sweep_checker.sv
// Exhaustive sweep driver/checker comparing an original and an optimized PLA netlist.
// Define SWEEP_SIG_EN to add a MISR signature of y_opt.
module pla_sweep_checker
  import pla_bench_pkg::*;
#(
  parameter int                N_IN             = N_IN_DEFAULT,
  parameter int                CNT_W            = N_IN + 1,
  parameter bit                STOP_ON_MISMATCH = 1'b0,
  parameter int                MISR_W           = MISR_W_DEFAULT,
  parameter logic [MISR_W-1:0] MISR_POLY        = MISR_POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  x,
  input  logic             y_ref,
  input  logic             y_opt,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [N_IN-1:0]  first_fail,
  output logic [CNT_W-1:0] ones_cnt
`ifdef SWEEP_SIG_EN
  ,
  output logic [MISR_W-1:0] signature
`endif
);

  sweep_state_e state, state_next;
  logic         start_ok;
  logic         mis;
  logic         last_vec;
  logic         stop_now;

  assign start_ok = start && (state != SWEEP);
  assign mis      = (y_ref != y_opt);
  assign last_vec = (x == {N_IN{1'b1}});
  assign stop_now = STOP_ON_MISMATCH && mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SWEEP;
      SWEEP:   if (last_vec || stop_now) state_next = DONE;
      DONE:    if (start) state_next = SWEEP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SWEEP);
    done = (state == DONE);
    pass = (state == DONE) && (mismatch_cnt == '0);
  end

  // Per-vector sampling: y_* belong to the x held during this cycle.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      x            <= '0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
      ones_cnt     <= '0;
    end else if (state == SWEEP) begin
      if (mis) begin
        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (mismatch_cnt == '0) first_fail <= x;
      end
      if (y_opt) ones_cnt <= ones_cnt + CNT_W'(1);
      // Stopping on a mismatch leaves the failing vector on x; the final
      // vector wraps x back to zero.
      if (!stop_now) x <= x + N_IN'(1);
    end
  end

`ifdef SWEEP_SIG_EN
  pla_misr #(
    .WIDTH (MISR_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .en  (state == SWEEP),
    .clr (start_ok),
    .din (y_opt),
    .sig (signature)
  );
`endif

endmodule

// File: tb/tb_pla_sweep_checker.sv
// Directed bench for pla_sweep_checker: three configurations share one clock,
// expected results come from a bench-side model through a scoreboard queue.
module tb_pla_sweep_checker;

  typedef struct {
    int mis;
    int ff;
    int ones;
    int pss;
    int cycles;
    int xend;
  } exp_t;

  exp_t exp_q[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic       mode_a = 1'b0;
  logic       mode_b = 1'b1;

  logic [3:0]  x_a, x_b;
  logic [15:0] x_c;
  logic [4:0]  mis_a, mis_b, ones_a, ones_b;
  logic [16:0] mis_c, ones_c;
  logic [3:0]  ff_a, ff_b;
  logic [15:0] ff_c;
  logic [2:0]  busy_v, done_v, pass_v;
  logic        yr_a, yo_a, yr_b, yo_b;
`ifdef SWEEP_SIG_EN
  logic [15:0] sig_a, sig_b, sig_c;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  function automatic bit yref_f(input int v);
    return v[0] & v[3];
  endfunction

  function automatic bit yopt_f(input int v, input bit m);
    return yref_f(v) ^ (m && (v == 10));
  endfunction

  assign yr_a = yref_f(int'(x_a));
  assign yo_a = yopt_f(int'(x_a), mode_a);
  assign yr_b = yref_f(int'(x_b));
  assign yo_b = yopt_f(int'(x_b), mode_b);

  pla_sweep_checker #(.N_IN(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .x(x_a), .y_ref(yr_a), .y_opt(yo_a),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .mismatch_cnt(mis_a), .first_fail(ff_a), .ones_cnt(ones_a)
`ifdef SWEEP_SIG_EN
    , .signature(sig_a)
`endif
  );

  pla_sweep_checker #(.N_IN(4), .STOP_ON_MISMATCH(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .x(x_b), .y_ref(yr_b), .y_opt(yo_b),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .mismatch_cnt(mis_b), .first_fail(ff_b), .ones_cnt(ones_b)
`ifdef SWEEP_SIG_EN
    , .signature(sig_b)
`endif
  );

  pla_sweep_checker #(.N_IN(16)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .x(x_c), .y_ref(1'b1), .y_opt(1'b1),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .mismatch_cnt(mis_c), .first_fail(ff_c), .ones_cnt(ones_c)
`ifdef SWEEP_SIG_EN
    , .signature(sig_c)
`endif
  );

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Reference model of a 4-input sweep (with optional stop on first mismatch).
  task automatic model4(input bit m, input bit stop);
    exp_t e;
    e = '{mis: 0, ff: 0, ones: 0, pss: 0, cycles: 0, xend: 0};
    for (int v = 0; v < 16; v++) begin
      e.cycles++;
      if (yopt_f(v, m)) e.ones++;
      if (yref_f(v) != yopt_f(v, m)) begin
        if (e.mis == 0) e.ff = v;
        e.mis++;
        if (stop) begin
          e.xend = v;
          break;
        end
      end
    end
    e.pss = (e.mis == 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  function automatic int get_x(input int k);
    case (k)
      0: return int'(x_a);
      1: return int'(x_b);
      default: return int'(x_c);
    endcase
  endfunction

  // Pulse start on DUT k and count busy cycles until done (bounded).
  // abort_at >= 0 asserts rst after that many busy cycles; mid_at re-pulses start.
  task automatic sweep(input int k, input int budget, input int abort_at, input int mid_at,
                       output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (done_v[k]) begin
        ok = 1'b1;
        break;
      end
      if (busy_v[k]) cyc++;
      if (abort_at >= 0 && cyc == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        return;
      end
      start_v[k] = (cyc == mid_at);
      @(negedge clk);
      start_v[k] = 1'b0;
    end
    if (!ok) chk($sformatf("timeout_dut%0d", k), 0, 1);
  endtask

  task automatic check_small(input int k, input string nm, input int cyc);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({nm, "_scoreboard_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, "_cycles"}, cyc, e.cycles);
    chk({nm, "_mismatch"}, (k == 0) ? int'(mis_a) : int'(mis_b), e.mis);
    chk({nm, "_first_fail"}, (k == 0) ? int'(ff_a) : int'(ff_b), e.ff);
    chk({nm, "_ones"}, (k == 0) ? int'(ones_a) : int'(ones_b), e.ones);
    chk({nm, "_pass"}, int'(pass_v[k]), e.pss);
    chk({nm, "_x_end"}, get_x(k), e.xend);
    chk({nm, "_done"}, int'(done_v[k]), 1);
    chk({nm, "_busy"}, int'(busy_v[k]), 0);
  endtask

`ifdef SWEEP_SIG_EN
  function automatic int golden_sig();
    logic [15:0] s;
    s = '0;
    for (int v = 0; v < 16; v++) begin
      s = (s << 1) ^ (s[15] ? 16'h8016 : 16'h0000) ^ {15'd0, yopt_f(v, mode_a)};
    end
    return int'(s);
  endfunction
`endif

  initial begin
    int cyc;
    bit ok;
    int sig1;
    sig1 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_x", int'(x_a), 0);
    chk("rst_busy", int'(busy_v[0]), 0);
    chk("rst_done", int'(done_v[0]), 0);
    chk("rst_pass", int'(pass_v[0]), 0);
    chk("rst_mismatch", int'(mis_a), 0);
    chk("rst_first_fail", int'(ff_a), 0);
    chk("rst_ones", int'(ones_a), 0);

    // Identical netlists
    mode_a = 1'b0;
    model4(1'b0, 1'b0);
    sweep(0, 40, -1, -1, cyc, ok);
    check_small(0, "ident", cyc);
`ifdef SWEEP_SIG_EN
    sig1 = int'(sig_a);
    chk("sig_golden", sig1, golden_sig());
    chk("sig_held", int'(sig_a), sig1);
`endif

    // Single mismatch at 4'hA, restarted from DONE
    mode_a = 1'b1;
    model4(1'b1, 1'b0);
    sweep(0, 40, -1, -1, cyc, ok);
    check_small(0, "onemis", cyc);

    // Same netlists with stop on first mismatch
    model4(1'b1, 1'b1);
    sweep(1, 40, -1, -1, cyc, ok);
    check_small(1, "stop", cyc);
    chk("stop_x_hold", int'(x_b), 10);

    // Reset mid-sweep, then a clean rerun
    mode_a = 1'b0;
    sweep(0, 40, 7, -1, cyc, ok);
    chk("abort_busy", int'(busy_v[0]), 0);
    chk("abort_done", int'(done_v[0]), 0);
    chk("abort_mismatch", int'(mis_a), 0);
    chk("abort_ones", int'(ones_a), 0);
    chk("abort_x", int'(x_a), 0);
    model4(1'b0, 1'b0);
    sweep(0, 40, -1, -1, cyc, ok);
    check_small(0, "rerun", cyc);
`ifdef SWEEP_SIG_EN
    chk("sig_repeat", int'(sig_a), sig1);
`endif

    // Full 16-input sweep with y_opt tied high and a stray start mid-sweep
    exp_q.push_back('{mis: 0, ff: 0, ones: 65536, pss: 1, cycles: 65536, xend: 0});
    sweep(2, 70000, -1, 100, cyc, ok);
    begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wide_cycles", cyc, e.cycles);
      chk("wide_ones", int'(ones_c), e.ones);
      chk("wide_mismatch", int'(mis_c), e.mis);
      chk("wide_first_fail", int'(ff_c), e.ff);
      chk("wide_pass", int'(pass_v[2]), e.pss);
      chk("wide_x_end", int'(x_c), e.xend);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
